codix_risc_dbus_responder: RTL

Memory-mapped peripheral that sits on the responder side of the codix_risc data bus (dbus), alongside mem.read_write on the platform interconnect.
- Accepts read/write requests on the A0/SI0/SC0/REQCMD0/REQRESP0 request channel.
- Returns read data on the Q0/IFCMD0/IFRESP0 channel and takes write data on the D0/OFCMD0/OFRESP0 channel.
- Implements a small register window that drives port_out/port_out_en/port_halt/port_error, so simulation can observe program output without the core's own ports.

---
 rtl/codix_risc_dbus_responder_if.sv | 25 ++
 rtl/codix_risc_dbus_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/codix_risc_dbus_responder_if.sv
// codix_risc data bus (dbus) responder-side signal bundle.
// Request, read-data and write-data channels grouped for one port.
interface codix_risc_dbus_responder_if;
    logic [31:0] A0;
    logic [1:0]  SI0;
    logic        SC0;
    logic [1:0]  REQCMD0;
    logic        REQRESP0;
    logic [31:0] Q0;
    logic        IFCMD0;
    logic        IFRESP0;
    logic [31:0] D0;
    logic        OFCMD0;
    logic        OFRESP0;

    modport master (
        output A0, SI0, SC0, REQCMD0, IFCMD0, D0, OFCMD0,
        input  REQRESP0, Q0, IFRESP0, OFRESP0
    );

    modport slave (
        input  A0, SI0, SC0, REQCMD0, IFCMD0, D0, OFCMD0,
        output REQRESP0, Q0, IFRESP0, OFRESP0
    );
endinterface

// File: rtl/codix_risc_dbus_responder.sv
// codix_risc dbus responder: register window for program output,
// halt/error flags and a free-running cycle counter.
module codix_risc_dbus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
    parameter int          WAIT_STATES = 1,
    parameter int          CNT_W       = 32
) (
    input  logic        CLK,
    input  logic        RST,
    codix_risc_dbus_responder_if.slave dbus,
    output logic [31:0] port_out,
    output logic        port_out_en,
    output logic        port_halt,
    output logic        port_error
);
    typedef enum logic [1:0] {IDLE, WAIT, RDATA, WDATA} state_e;

    localparam logic [3:0] WS_INIT =
        4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_e           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic             sc_q, sc_d;
    logic             wr_q, wr_d;
    logic [31:0]      q_q, q_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      out_q, out_d;
    logic             out_en_q, out_en_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        accept;
    logic        commit;
    logic        rd_done;
    logic        wr_ok;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_sc;
    logic [31:0] offset;
    logic [2:0]  idx;
    logic        hit;
    logic        bad;
    logic [31:0] reg_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign accept  = (state_q == IDLE) &&
                     (dbus.REQCMD0 == 2'd1 || dbus.REQCMD0 == 2'd2);
    assign commit  = (state_q == WDATA) && dbus.OFCMD0;
    assign rd_done = (state_q == RDATA) && dbus.IFCMD0;

    // Decode from the live bus in IDLE so zero-wait reads work too.
    assign sel_addr = (state_q == IDLE) ? dbus.A0  : addr_q;
    assign sel_size = (state_q == IDLE) ? dbus.SI0 : size_q;
    assign sel_sc   = (state_q == IDLE) ? dbus.SC0 : sc_q;

    assign offset = sel_addr - BASE_ADDR;
    assign idx    = offset[4:2];
    assign hit    = offset < 32'h14;
    assign bad    = !hit || sel_size == 2'd3 ||
                    (sel_size == 2'd1 && sel_addr[0]) ||
                    (sel_size == 2'd2 && |sel_addr[1:0]);

    always_comb begin
        reg_word = '0;
        case (idx)
            3'd0:    reg_word = scratch_q;
            3'd1:    reg_word = out_q;
            3'd2:    reg_word = {31'b0, halt_q};
            3'd3:    reg_word = 32'(cnt_q);
            3'd4:    reg_word = {31'b0, err_q};
            default: reg_word = '0;
        endcase
    end

    assign rd_byte = reg_word[{sel_addr[1:0], 3'b000} +: 8];
    assign rd_half = sel_addr[1] ? reg_word[31:16] : reg_word[15:0];

    always_comb begin
        rd_val    = reg_word;
        lane_mask = '1;
        unique case (1'b1)
            sel_size == 2'd0: begin
                rd_val    = {{24{sel_sc & rd_byte[7]}}, rd_byte};
                lane_mask = 32'hFF << {sel_addr[1:0], 3'b000};
            end
            sel_size == 2'd1: begin
                rd_val    = {{16{sel_sc & rd_half[15]}}, rd_half};
                lane_mask = sel_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            default: ;
        endcase
        if (bad) rd_val = '0;
    end

    assign merged = (reg_word & ~lane_mask) | (dbus.D0 & lane_mask);
    assign wr_ok  = commit && !bad;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        addr_d        = addr_q;
        size_d        = size_q;
        sc_d          = sc_q;
        wr_d          = wr_q;
        dbus.REQRESP0 = 1'b0;
        dbus.IFRESP0  = 1'b0;
        dbus.OFRESP0  = 1'b0;
        dbus.Q0       = '0;
        unique case (state_q)
            IDLE: begin
                dbus.REQRESP0 = 1'b1;
                if (accept) begin
                    addr_d = dbus.A0;
                    size_d = dbus.SI0;
                    sc_d   = dbus.SC0;
                    wr_d   = dbus.REQCMD0 == 2'd2;
                    wcnt_d = WS_INIT;
                    if (WAIT_STATES == 0)
                        state_d = (dbus.REQCMD0 == 2'd2) ? WDATA : RDATA;
                    else
                        state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0)
                    state_d = wr_q ? WDATA : RDATA;
                else
                    wcnt_d = wcnt_q - 4'd1;
            end
            RDATA: begin
                dbus.IFRESP0 = 1'b1;
                dbus.Q0      = q_q;
                if (dbus.IFCMD0) state_d = IDLE;
            end
            WDATA: begin
                dbus.OFRESP0 = 1'b1;
                if (dbus.OFCMD0) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        q_d       = q_q;
        scratch_d = scratch_q;
        out_d     = out_q;
        out_en_d  = 1'b0;
        halt_d    = halt_q;
        err_d     = err_q;
        cnt_d     = cnt_q + CNT_W'(1);
        if (state_d == RDATA && state_q != RDATA) q_d = rd_val;
        if (wr_ok) begin
            case (idx)
                3'd0: scratch_d = merged;
                3'd1: begin
                    out_d    = merged;
                    out_en_d = 1'b1;
                end
                3'd2: if (lane_mask[0] && dbus.D0[0]) halt_d = 1'b1;
                3'd3: cnt_d = '0;
                3'd4: if (lane_mask[0] && dbus.D0[0]) err_d = 1'b0;
                default: ;
            endcase
        end
        // A new error wins over a same-cycle clear.
        if ((commit || rd_done) && bad) err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            sc_q      <= 1'b0;
            wr_q      <= 1'b0;
            q_q       <= '0;
            scratch_q <= '0;
            out_q     <= '0;
            out_en_q  <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            sc_q      <= sc_d;
            wr_q      <= wr_d;
            q_q       <= q_d;
            scratch_q <= scratch_d;
            out_q     <= out_d;
            out_en_q  <= out_en_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign port_out    = out_q;
    assign port_out_en = out_en_q;
    assign port_halt   = halt_q;
    assign port_error  = err_q;
endmodule
